// File: rtl/ltc2387_16_tx_emulator_pkg.sv
// Shared LTC2387-16 definitions: FSM state codes, lane geometry and defaults,
// plus the word-to-lane split used by both the emulator and the receiver.
package ltc2387_pkg;

   localparam int LANE_BITS     = 8;
   localparam int DEF_LAT_EDGES = 4;
   localparam int DEF_DCO_HALF  = 2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LAT   = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;

   typedef struct packed {
      logic [LANE_BITS-1:0] odd;
      logic [LANE_BITS-1:0] even;
   } lanes_t;

   // odd[7] = D15 ... odd[0] = D1; even[7] = D14 ... even[0] = D0
   function automatic lanes_t split_word(
      input logic [2*LANE_BITS-1:0] w
   );
      lanes_t l;
      for (int i = 0; i < LANE_BITS; i++) begin
         l.odd[i]  = w[2*i+1];
         l.even[i] = w[2*i];
      end
      return l;
   endfunction

endpackage

// File: rtl/ltc2387_16_tx_emulator_if.sv
// Sample handshake into the LTC2387-16 emulator.
// master = sample source, slave = emulator.
interface ltc2387_16_tx_emulator_if;
   import ltc2387_pkg::*;

   logic [2*LANE_BITS-1:0] sample_data;
   logic                   sample_valid;
   logic                   sample_ready;

   modport master (
      output sample_data,
      output sample_valid,
      input  sample_ready
   );

   modport slave (
      input  sample_data,
      input  sample_valid,
      output sample_ready
   );

endinterface

// File: rtl/ltc2387_16_tx_emulator_dco_gen.sv
// Free-running DCO divider: toggles every DCO_HALF sys_clk cycles and
// flags the cycle in which a rising or falling toggle takes effect.
module ltc2387_dco_gen
   import ltc2387_pkg::*;
#(
   parameter int DCO_HALF = DEF_DCO_HALF
) (
   input  logic sys_clk,
   input  logic reset,
   output logic dco,
   output logic dco_rise,
   output logic dco_fall
);

   localparam int CW = (DCO_HALF > 1) ? $clog2(DCO_HALF) : 1;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          dco_q;
   logic          dco_d;
   logic          tick;

   always_comb begin
      tick  = (cnt_q == CW'(DCO_HALF - 1));
      cnt_d = tick ? '0 : cnt_q + CW'(1);
      dco_d = dco_q ^ tick;
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         cnt_q <= '0;
         dco_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         dco_q <= dco_d;
      end
   end

   assign dco      = dco_q;
   assign dco_rise = tick & ~dco_q;
   assign dco_fall = tick & dco_q;

endmodule

// File: rtl/ltc2387_16_tx_emulator.sv
// LTC2387-16 dual-lane transmitter model: DCO plus DATA1/DATA2 per CNV.
// Define LTC2387_TEST_PATTERN_EN to add the test_pattern ramp source.
module ltc2387_16_tx_emulator
   import ltc2387_pkg::*;
#(
   parameter int DCO_HALF  = DEF_DCO_HALF,
   parameter int LAT_EDGES = DEF_LAT_EDGES,
   parameter int NBITS     = 2 * LANE_BITS
) (
   input  logic                       sys_clk,
   input  logic                       reset,
   ltc2387_16_tx_emulator_if.slave    s_if,
   input  logic                       cnv,
`ifdef LTC2387_TEST_PATTERN_EN
   input  logic                       test_pattern,
`endif
   output logic                       dco,
   output logic                       data1,
   output logic                       data2,
   output logic                       frame_busy,
   output logic                       frame_done,
   output logic                       underrun,
   output logic                       overlap
);

   localparam int LCW = (LAT_EDGES > 0) ? $clog2(LAT_EDGES + 1) : 1;

   logic                 dco_rise;
   logic                 dco_fall;

   logic                 cnv_q;
   logic                 pend_q;
   logic                 pend_d;
   logic [1:0]           state_q;
   logic [1:0]           state_d;
   logic [LCW-1:0]       cnt_q;
   logic [LCW-1:0]       cnt_d;
   logic [2:0]           pair_q;
   logic [2:0]           pair_d;
   logic [LANE_BITS-1:0] sh1_q;
   logic [LANE_BITS-1:0] sh1_d;
   logic [LANE_BITS-1:0] sh2_q;
   logic [LANE_BITS-1:0] sh2_d;
   logic                 d1_q;
   logic                 d1_d;
   logic                 d2_q;
   logic                 d2_d;
   logic                 done_q;
   logic                 done_d;
   logic [NBITS-1:0]     hold_q;
   logic [NBITS-1:0]     hold_d;
   logic                 full_q;
   logic                 full_d;
   logic [NBITS-1:0]     last_q;
   logic [NBITS-1:0]     last_d;
   logic                 und_q;
   logic                 und_d;
   logic                 ovl_q;
   logic                 ovl_d;

   logic                 cnv_rise;
   logic                 busy;
   logic                 r0;
   logic                 load;
   logic                 use_ramp;
   logic [NBITS-1:0]     src;
   lanes_t               lanes;

`ifdef LTC2387_TEST_PATTERN_EN
   logic [NBITS-1:0]     ramp_q;
   logic [NBITS-1:0]     ramp_d;
   assign use_ramp = test_pattern;
`else
   assign use_ramp = 1'b0;
`endif

   ltc2387_dco_gen #(
      .DCO_HALF (DCO_HALF)
   ) u_dco (
      .sys_clk  (sys_clk),
      .reset    (reset),
      .dco      (dco),
      .dco_rise (dco_rise),
      .dco_fall (dco_fall)
   );

   always_comb begin
      cnv_rise = cnv & ~cnv_q;
      busy     = (state_q != ST_IDLE);
      r0       = ~busy & pend_q & dco_rise;
      load     = s_if.sample_valid & ~full_q;
      src      = full_q ? hold_q : last_q;
`ifdef LTC2387_TEST_PATTERN_EN
      if (use_ramp) src = ramp_q;
      ramp_d = ramp_q;
`endif
      lanes = split_word(src);

      state_d = state_q;
      cnt_d   = cnt_q;
      pair_d  = pair_q;
      sh1_d   = sh1_q;
      sh2_d   = sh2_q;
      d1_d    = d1_q;
      d2_d    = d2_q;
      done_d  = 1'b0;
      hold_d  = hold_q;
      full_d  = full_q;
      last_d  = last_q;
      und_d   = und_q;
      // a CNV edge landing on R0 or later belongs to a running frame
      ovl_d   = ovl_q | (cnv_rise & (busy | r0));
      pend_d  = (pend_q & ~r0) | (cnv_rise & ~busy & ~r0);

      unique case (1'b1)
         state_q == ST_IDLE: begin
            if (dco_fall) begin
               d1_d = 1'b0;
               d2_d = 1'b0;
            end
            if (r0) begin
               sh1_d   = lanes.odd;
               sh2_d   = lanes.even;
               cnt_d   = '0;
               state_d = ST_LAT;
               if (!use_ramp) begin
                  full_d = 1'b0;
                  if (full_q) last_d = hold_q;
                  else        und_d  = 1'b1;
               end
`ifdef LTC2387_TEST_PATTERN_EN
               if (use_ramp) ramp_d = ramp_q + NBITS'(1);
`endif
            end
         end
         state_q == ST_LAT: begin
            if (dco_rise) cnt_d = cnt_q + LCW'(1);
            if (dco_fall && cnt_q == LCW'(LAT_EDGES)) begin
               d1_d    = sh1_q[LANE_BITS-1];
               d2_d    = sh2_q[LANE_BITS-1];
               sh1_d   = {sh1_q[LANE_BITS-2:0], 1'b0};
               sh2_d   = {sh2_q[LANE_BITS-2:0], 1'b0};
               pair_d  = '0;
               state_d = ST_SHIFT;
            end
         end
         state_q == ST_SHIFT: begin
            if (dco_rise) begin
               if (pair_q == 3'd7) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  pair_d = pair_q + 3'd1;
               end
            end
            if (dco_fall) begin
               d1_d  = sh1_q[LANE_BITS-1];
               d2_d  = sh2_q[LANE_BITS-1];
               sh1_d = {sh1_q[LANE_BITS-2:0], 1'b0};
               sh2_d = {sh2_q[LANE_BITS-2:0], 1'b0};
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // loads only when empty, so a same-cycle R0 already took last_q
      if (load) begin
         hold_d = s_if.sample_data;
         full_d = 1'b1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         cnv_q   <= 1'b0;
         pend_q  <= 1'b0;
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         pair_q  <= '0;
         sh1_q   <= '0;
         sh2_q   <= '0;
         d1_q    <= 1'b0;
         d2_q    <= 1'b0;
         done_q  <= 1'b0;
         hold_q  <= '0;
         full_q  <= 1'b0;
         last_q  <= '0;
         und_q   <= 1'b0;
         ovl_q   <= 1'b0;
`ifdef LTC2387_TEST_PATTERN_EN
         ramp_q  <= '0;
`endif
      end else begin
         cnv_q   <= cnv;
         pend_q  <= pend_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pair_q  <= pair_d;
         sh1_q   <= sh1_d;
         sh2_q   <= sh2_d;
         d1_q    <= d1_d;
         d2_q    <= d2_d;
         done_q  <= done_d;
         hold_q  <= hold_d;
         full_q  <= full_d;
         last_q  <= last_d;
         und_q   <= und_d;
         ovl_q   <= ovl_d;
`ifdef LTC2387_TEST_PATTERN_EN
         ramp_q  <= ramp_d;
`endif
      end
   end

   assign s_if.sample_ready = ~full_q;
   assign data1             = d1_q;
   assign data2             = d2_q;
   assign frame_busy        = busy;
   assign frame_done        = done_q;
   assign underrun          = und_q;
   assign overlap           = ovl_q;

endmodule

// File: tb/tb_ltc2387_16_tx_emulator.sv
// Scoreboard bench for ltc2387_16_tx_emulator: expected words queued at CNV,
// a lane monitor rebuilds each frame from DCO/DATA1/DATA2 and compares.
module tb_ltc2387_16_tx_emulator;

   localparam int LAT = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic cnv = 1'b0;
   logic dco, data1, data2;
   logic frame_busy, frame_done, underrun, overlap;
`ifdef LTC2387_TEST_PATTERN_EN
   logic test_pattern = 1'b0;
`endif

   ltc2387_16_tx_emulator_if s_if ();

   always #5 clk = ~clk;

   ltc2387_16_tx_emulator dut (
      .sys_clk      (clk),
      .reset        (reset),
      .s_if         (s_if),
      .cnv          (cnv),
`ifdef LTC2387_TEST_PATTERN_EN
      .test_pattern (test_pattern),
`endif
      .dco          (dco),
      .data1        (data1),
      .data2        (data2),
      .frame_busy   (frame_busy),
      .frame_done   (frame_done),
      .underrun     (underrun),
      .overlap      (overlap)
   );

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [15:0] exp_q[$];
   bit          m_full = 0;
   logic [15:0] m_hold = '0;
   logic [15:0] m_last = '0;
   bit          m_und = 0;
   bit          m_ovl = 0;
   logic [15:0] m_ramp = '0;
   int          m_frames = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // lane monitor: R0 is the DCO rise on which frame_busy appears
   logic        prev_dco = 1'b0;
   logic        prev_busy = 1'b0;
   bit          active = 0;
   int          n = 0;
   int          k;
   int          done_cnt = 0;
   bit          want_done;
   logic [15:0] word = '0;

   always @(negedge clk) begin
      want_done = 0;
      if (reset) begin
         active    = 0;
         prev_dco  = 1'b0;
         prev_busy = 1'b0;
      end else begin
         if (dco && !prev_dco) begin
            if (frame_busy && !prev_busy) begin
               active = 1;
               n      = 0;
               chk("r0_lanes", {data1, data2}, 2'b00);
            end else if (active) begin
               n++;
               if (n <= LAT) begin
                  chk("lat_lanes", {data1, data2}, 2'b00);
               end else begin
                  k = n - LAT - 1;
                  word[15-2*k] = data1;
                  word[14-2*k] = data2;
               end
               if (n == LAT + 8) begin
                  want_done = 1;
                  active    = 0;
                  chk("end_busy", frame_busy, 1'b0);
                  if (exp_q.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL unexpected_frame: got %h expected none",
                              word);
                  end else begin
                     chk("frame_word", word, exp_q.pop_front());
                  end
               end else begin
                  chk("mid_busy", frame_busy, 1'b1);
               end
            end
         end
         if (frame_done || want_done)
            chk("frame_done", frame_done, want_done);
         if (frame_done) done_cnt++;
         prev_dco  = dco;
         prev_busy = frame_busy;
      end
   end

   task automatic load(input logic [15:0] v);
      @(negedge clk);
      chk("ready_before_load", s_if.sample_ready, !m_full);
      s_if.sample_data  = v;
      s_if.sample_valid = 1'b1;
      @(negedge clk);
      s_if.sample_valid = 1'b0;
      if (!m_full) begin
         m_full = 1;
         m_hold = v;
      end
   endtask

   task automatic pulse_cnv(input int len);
      @(negedge clk);
      cnv = 1'b1;
      repeat (len) @(negedge clk);
      cnv = 1'b0;
   endtask

   // frame content is fixed now: nothing touches hold before R0
   task automatic fire(input bit ramp);
      if (ramp) begin
         exp_q.push_back(m_ramp);
         m_ramp++;
      end else if (m_full) begin
         exp_q.push_back(m_hold);
         m_last = m_hold;
         m_full = 0;
      end else begin
         exp_q.push_back(m_last);
         m_und = 1;
      end
      m_frames++;
      pulse_cnv(8 + $urandom_range(0, 6));
   endtask

   task automatic wait_frame();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || frame_busy) && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (t >= 400) begin
         checks++;
         errors++;
         $display("FAIL frame_timeout: got %0d pending expected 0",
                  exp_q.size());
         exp_q.delete();
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic post_checks();
      chk("idle_lanes", {data1, data2}, 2'b00);
      chk("underrun", underrun, m_und);
      chk("overlap", overlap, m_ovl);
      chk("sample_ready", s_if.sample_ready, !m_full);
      chk("done_count", done_cnt, m_frames);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      s_if.sample_valid = 1'b0;
      s_if.sample_data  = '0;
      repeat (3) @(negedge clk);
      chk("rst_dco", dco, 1'b0);
      chk("rst_lanes", {data1, data2}, 2'b00);
      chk("rst_ready", s_if.sample_ready, 1'b1);
      chk("rst_busy", frame_busy, 1'b0);
      chk("rst_done", frame_done, 1'b0);
      chk("rst_flags", {underrun, overlap}, 2'b00);
      reset = 1'b0;

      load(16'hA5C3); fire(0); wait_frame(); post_checks();
      load(16'h8001); fire(0); wait_frame(); post_checks();
      load(16'h1234); fire(0); wait_frame(); post_checks();
      fire(0); wait_frame(); post_checks();

      for (int i = 0; i < 16; i++) begin
         if (!m_full && $urandom_range(0, 3) != 0) load(16'($urandom));
         repeat ($urandom_range(0, 5)) @(negedge clk);
         fire(0);
         if (!m_full && $urandom_range(0, 1) != 0) load(16'($urandom));
         wait_frame();
         post_checks();
      end

      // second CNV mid-frame
      if (!m_full) load(16'h5A5A);
      fire(0);
      repeat (12) @(negedge clk);
      pulse_cnv(8);
      m_ovl = 1;
      wait_frame();
      post_checks();

      // reset mid-frame
      if (!m_full) load(16'hBEEF);
      fire(0);
      repeat (12) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_dco", dco, 1'b0);
      chk("midrst_lanes", {data1, data2}, 2'b00);
      chk("midrst_busy", frame_busy, 1'b0);
      chk("midrst_done", frame_done, 1'b0);
      chk("midrst_flags", {underrun, overlap}, 2'b00);
      chk("midrst_ready", s_if.sample_ready, 1'b1);
      reset = 1'b0;
      exp_q.delete();
      m_full = 0;
      m_hold = '0;
      m_last = '0;
      m_und  = 0;
      m_ovl  = 0;
      m_ramp = '0;
      m_frames--;
      load(16'hC0DE); fire(0); wait_frame(); post_checks();

`ifdef LTC2387_TEST_PATTERN_EN
      load(16'h7777);
      test_pattern = 1'b1;
      repeat (3) begin
         fire(1);
         wait_frame();
         post_checks();
      end
      test_pattern = 1'b0;
      fire(0); wait_frame(); post_checks();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
